demux_using_reg: RTL and testbench

- Registered 1:N demultiplexer, the distributing counterpart of the team's 2:1 selection muxes.
- Routes one input stream to one of N_OUT output streams, chosen per word by a select field.
- Each output has a one-entry holding register with valid/ready handshake, so a stalled consumer blocks only its own lane.
- Sits between a single producer and N_OUT independent consumers.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_slot.sv | 42 ++++
 rtl/demux_using_reg.sv | 88 ++++++++
 tb/tb_demux_using_reg.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the registered 1:N demultiplexer.
package demux_pkg;

    localparam int unsigned DEMUX_WIDTH = 8;
    localparam int unsigned DEMUX_N_OUT = 4;
    localparam int unsigned DEMUX_SEL_W = 2;
    localparam int unsigned DEMUX_CNT_W = 16;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
        logic [31:0] max_val;
        max_val = (32'd1 << w) - 32'd1;
        return (val == max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register: load wins over drain, so a lane can refill while it empties.
module demux_slot #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] data_i,
    input  logic             load_i,
    input  logic             drain_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o
);

    logic [Width-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (drain_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux_using_reg.sv
// Registered 1:N demultiplexer with per-lane holding slots, drop handling and saturating counters.
module demux_using_reg
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH,
    parameter int unsigned N_OUT = DEMUX_N_OUT,
    parameter int unsigned SEL_W = DEMUX_SEL_W,
    parameter int unsigned CNT_W = DEMUX_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       din,
    input  logic [SEL_W-1:0]       din_sel,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [N_OUT*WIDTH-1:0] dout,
    output logic [N_OUT-1:0]       dout_valid,
    input  logic [N_OUT-1:0]       dout_ready,
    output logic                   drop_pulse,
    output logic [CNT_W-1:0]       acc_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    logic [N_OUT-1:0] sel_hot;
    logic [N_OUT-1:0] lane_free;
    logic [N_OUT-1:0] load;
    logic             in_range;
    logic             accept;
    logic             drop;
    logic             drop_pulse_d, drop_pulse_q;
    logic [CNT_W-1:0] acc_cnt_d, acc_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;

    // Ready is a combinational mux of the selected lane's free state; out-of-range
    // selects are always accepted so they can be discarded.
    always_comb begin
        sel_hot = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            sel_hot[k] = (32'(din_sel) == k);
        end
        in_range     = |sel_hot;
        lane_free    = ~dout_valid | dout_ready;
        din_ready    = in_range ? |(sel_hot & lane_free) : 1'b1;
        accept       = din_valid && din_ready;
        load         = sel_hot & {N_OUT{accept}};
        drop         = accept && !in_range;
        drop_pulse_d = drop;
        acc_cnt_d    = acc_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        if (|load) begin
            acc_cnt_d = CNT_W'(sat_inc(32'(acc_cnt_q), CNT_W));
        end
        if (drop) begin
            drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_pulse_q <= 1'b0;
            acc_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            acc_cnt_q    <= acc_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        demux_slot #(
            .Width(WIDTH)
        ) u_slot (
            .clk_i  (clk),
            .rst_ni (reset_n),
            .data_i (din),
            .load_i (load[k]),
            .drain_i(dout_valid[k] && dout_ready[k]),
            .data_o (dout[k*WIDTH +: WIDTH]),
            .valid_o(dout_valid[k])
        );
    end

    assign drop_pulse = drop_pulse_q;
    assign acc_cnt    = acc_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_demux_using_reg.sv
// Scoreboard bench: sends push expected words per lane, a negedge monitor pops on each drain.
module tb_demux_using_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  din;
    logic [1:0]  din_sel;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] dout;
    logic [3:0]  dout_valid;
    logic [3:0]  dout_ready;
    logic        drop_pulse;
    logic [15:0] acc_cnt;
    logic [15:0] drop_cnt;

    logic [7:0]  s_din;
    logic [1:0]  s_sel;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_dout;
    logic [2:0]  s_dout_valid;
    logic [2:0]  s_dout_ready;
    logic        s_drop_pulse;
    logic [3:0]  s_acc_cnt;
    logic [3:0]  s_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_acc  = 0;

    logic [7:0] q0[$], q1[$], q2[$], q3[$];
    logic [3:0] pv;
    logic [7:0] pd [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux_using_reg u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (din),
        .din_sel   (din_sel),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .drop_pulse(drop_pulse),
        .acc_cnt   (acc_cnt),
        .drop_cnt  (drop_cnt)
    );

    demux_using_reg #(
        .WIDTH(8),
        .N_OUT(3),
        .SEL_W(2),
        .CNT_W(4)
    ) u_small (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (s_din),
        .din_sel   (s_sel),
        .din_valid (s_valid),
        .din_ready (s_ready),
        .dout      (s_dout),
        .dout_valid(s_dout_valid),
        .dout_ready(s_dout_ready),
        .drop_pulse(s_drop_pulse),
        .acc_cnt   (s_acc_cnt),
        .drop_cnt  (s_drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int lane, input logic [7:0] d);
        case (lane)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic pop(input int lane, output bit ok, output logic [7:0] d);
        ok = 1'b0;
        d  = '0;
        case (lane)
            0: if (q0.size() > 0) begin d = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin d = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin d = q2.pop_front(); ok = 1'b1; end
            default: if (q3.size() > 0) begin d = q3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Offer one word for up to budget cycles; called and returns at posedge+1.
    task automatic send(input logic [7:0] d, input logic [1:0] s, input int budget,
                        output bit ok);
        din       = d;
        din_sel   = s;
        din_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (din_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            push(int'(s), d);
            exp_acc++;
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
    endtask

    // Monitor: hold-stability of stalled lanes and in-order delivery on each drain.
    always @(negedge clk) begin
        if (!reset_n) begin
            pv = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                bit         ok;
                logic [7:0] d;
                if (pv[k]) begin
                    chk($sformatf("hold_valid_l%0d", k), 32'(dout_valid[k]), 32'd1);
                    chk($sformatf("hold_data_l%0d", k), 32'(dout[k*8 +: 8]), 32'(pd[k]));
                end
                if (dout_valid[k] && dout_ready[k]) begin
                    pop(k, ok, d);
                    if (!ok) begin
                        chk($sformatf("unexpected_word_l%0d", k), 32'(dout[k*8 +: 8]), 32'hDEAD);
                    end else begin
                        chk($sformatf("lane%0d_data", k), 32'(dout[k*8 +: 8]), 32'(d));
                    end
                end
                pv[k] = dout_valid[k] && !dout_ready[k];
                pd[k] = dout[k*8 +: 8];
            end
        end
    end

    initial begin
        bit ok;
        int t0;
        reset_n    = 1'b0;
        din        = '0;
        din_sel    = '0;
        din_valid  = 1'b0;
        dout_ready = '0;
        s_din        = '0;
        s_sel        = '0;
        s_valid      = 1'b0;
        s_dout_ready = '0;
        pv           = '0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Mid-stream reset with lane 2 full
        send(8'h33, 2'd2, 2, ok);
        chk("pre_reset_accept", 32'(ok), 32'd1);
        @(negedge clk);
        chk("pre_reset_valid", 32'(dout_valid), 32'h4);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("reset_valid", 32'(dout_valid), 32'h0);
        chk("reset_dout", dout, 32'h0);
        chk("reset_acc", 32'(acc_cnt), 32'h0);
        chk("reset_drop", 32'(drop_cnt), 32'h0);
        chk("reset_pulse", 32'(drop_pulse), 32'h0);
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        exp_acc = 0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            din_sel = 2'(s);
            #1 chk($sformatf("idle_ready_sel%0d", s), 32'(din_ready), 32'd1);
        end
        @(posedge clk);
        #1;

        // Basic routing, one-cycle latency, then back-pressure on lane 2
        send(8'hA5, 2'd2, 2, ok);
        chk("basic_accept", 32'(ok), 32'd1);
        @(negedge clk);
        chk("basic_valid", 32'(dout_valid), 32'h4);
        chk("basic_data", 32'(dout[23:16]), 32'hA5);
        chk("basic_acc", 32'(acc_cnt), 32'd1);
        @(posedge clk);
        #1;
        send(8'h5A, 2'd2, 3, ok);
        chk("stalled_ready", 32'(ok), 32'd0);
        dout_ready[2] = 1'b1;
        send(8'h5A, 2'd2, 2, ok);
        chk("refill_accept", 32'(ok), 32'd1);
        @(negedge clk);
        chk("refill_valid", 32'(dout_valid[2]), 32'd1);
        chk("refill_data", 32'(dout[23:16]), 32'h5A);
        @(posedge clk);
        #1 dout_ready = '0;

        // Streaming 16 words on lane 1 with no bubble
        dout_ready[1] = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 16; i++) begin
            send(8'(i), 2'd1, 1, ok);
            chk($sformatf("stream_accept_%0d", i), 32'(ok), 32'd1);
        end
        chk("stream_cycles", 32'(cyc - t0), 32'd16);
        @(negedge clk);
        chk("stream_acc", 32'(acc_cnt), 32'(exp_acc));
        @(posedge clk);
        #1;

        // Lane isolation: lane 0 stalled, lane 3 flowing
        dout_ready = 4'b1000;
        send(8'hC0, 2'd0, 2, ok);
        chk("iso_fill", 32'(ok), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send(8'hD0 + 8'(i), 2'd0, 1, ok);
            chk($sformatf("iso_blocked_%0d", i), 32'(ok), 32'd0);
            send(8'hE0 + 8'(i), 2'd3, 1, ok);
            chk($sformatf("iso_flow_%0d", i), 32'(ok), 32'd1);
        end

        // Drain everything and confirm the scoreboard is empty
        dout_ready = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drain_q_total", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
        chk("final_acc", 32'(acc_cnt), 32'(exp_acc));
        chk("final_drop", 32'(drop_cnt), 32'd0);

        // Out-of-range select on the 3-lane instance
        @(posedge clk);
        #1;
        s_din   = 8'h77;
        s_sel   = 2'd3;
        s_valid = 1'b1;
        @(negedge clk);
        chk("oor_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        chk("oor_pulse", 32'(s_drop_pulse), 32'd1);
        chk("oor_drop_cnt", 32'(s_drop_cnt), 32'd1);
        chk("oor_valid", 32'(s_dout_valid), 32'd0);
        chk("oor_acc", 32'(s_acc_cnt), 32'd0);
        @(negedge clk);
        chk("oor_pulse_end", 32'(s_drop_pulse), 32'd0);

        // Saturation: 20 words into a 4-bit counter
        @(posedge clk);
        #1;
        s_dout_ready = 3'b111;
        s_sel        = 2'd1;
        s_valid      = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_din = 8'h40 + 8'(i);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("sat_acc", 32'(s_acc_cnt), 32'hF);
        chk("sat_last_data", 32'(s_dout[15:8]), 32'h53);
        chk("sat_drop_cnt", 32'(s_drop_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
